axi_lite_regbank: RTL and testbench
===================================

Name: axi_lite_regbank

Overview:
- Parametrised AXI4-Lite slave register bank. Next generation of the fixed four-register, 32-bit slave in the extraction IP.
- Generalised in data width and register count. Adds per-register mode (RW, RO, W1C), WSTRB byte enables, SLVERR on bad accesses, and per-register write strobes.
- Sits between the host AXI-Lite interconnect and the datapath control/status logic.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width in bits; 32 or 64.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; requires C_NUM_REGS <= 2^(C_S_AXI_ADDR_WIDTH-log2(DW/8)).
- C_NUM_REGS, 8, number of registers, 1..64.
- C_RO_MASK, 0, C_NUM_REGS-bit mask; bit i=1 makes register i read-only, value taken from hw_in.
- C_W1C_MASK, 0, C_NUM_REGS-bit mask; bit i=1 makes register i write-1-to-clear status; RO takes precedence.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  synchronous active-low reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
- S_AXI_WDATA  in  DW  write data
- S_AXI_WSTRB  in  DW/8  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
- S_AXI_BRESP  out  2  OKAY=00, SLVERR=10
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
- S_AXI_RDATA  out  DW  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
- reg_out  out  C_NUM_REGS*DW  current value of all registers; register i at [i*DW +: DW]
- hw_in  in  C_NUM_REGS*DW  source for RO registers
- hw_set  in  C_NUM_REGS*DW  per-bit set pulses for W1C registers
- wr_pulse  out  C_NUM_REGS  one-cycle pulse when register i accepts a write

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (S_AXI_ARESETN sampled on S_AXI_ACLK rising edge).
- Reset values: all registers 0; all READY/VALID outputs 0; BRESP, RRESP, RDATA 0; wr_pulse 0.
- Reset mid-transaction: the transaction is abandoned. VALIDs deassert in the cycle after reset is sampled, and no register write occurs.
- Address decode: index = ADDR[C_S_AXI_ADDR_WIDTH-1 : log2(DW/8)]; low address bits are ignored.
- Write FSM, state W_IDLE:
  - AWREADY=1 while no address is latched; WREADY=1 while no data is latched.
  - AW and W are accepted independently, in either order or in the same cycle, each latched on its handshake.
  - Once both are latched, the next edge performs the update, sets BVALID=1 and moves to W_RESP.
- Write FSM, state W_RESP:
  - AWREADY=WREADY=0.
  - Hold BVALID and BRESP until BREADY; on BVALID&BREADY go to W_IDLE.
  - Back-to-back throughput: at most one write per 3 cycles.
- Write effect by register type:
  - RW: byte k updated only where WSTRB[k]=1; BRESP=OKAY; wr_pulse[i]=1 in the update cycle.
  - W1C: reg <= (reg & ~(WDATA & strobe mask)) | hw_set[i]; a set wins over a clear on the same bit in the same cycle; BRESP=OKAY; wr_pulse[i]=1.
  - RO, or index >= C_NUM_REGS: no state change, BRESP=SLVERR, wr_pulse=0.
- W1C set outside writes: every cycle reg |= hw_set[i].
- RO registers: reg_out slice mirrors hw_in combinationally.
- Read FSM, state R_IDLE:
  - ARREADY=1.
  - On handshake, capture RDATA from the register value in that same cycle (RO: hw_in). Set RVALID=1 and go to R_DATA.
  - Latency: RVALID is asserted exactly one cycle after the AR handshake.
- Read FSM, state R_DATA:
  - ARREADY=0; hold RDATA and RRESP stable until RREADY; then go to R_IDLE.
- Out-of-range read: RDATA=0, RRESP=SLVERR. Reads never modify state.
- Simultaneous read and write to the same register in the same edge: the read returns the pre-write value.
- The read and write FSMs are fully independent.

Test Plan:
- Sequential RW: DW=32, NUM_REGS=8. Write 0x1..0x8 to addresses 0x00..0x1C, then read back -> each RDATA equals the value written, RRESP=00, BRESP=00, wr_pulse[i] pulses once per write.
- Byte strobe: reg0=0xAABBCCDD, then write 0x11223344 with WSTRB=0101 -> read returns 0xAA22CC44.
- Order independence: W presented 3 cycles before AW, then both in the same cycle -> both writes land, and BVALID rises one cycle after the second of AW/W is accepted.
- W1C and RO: reg2 is W1C. Pulse hw_set=0xF0, write 0x30 -> read 0xC0; write 0x40 while hw_set=0x40 -> bit 6 remains set. reg3 is RO with hw_in=0xDEAD -> read 0xDEAD; write -> BRESP=10, value unchanged.
- Error and backpressure: read of address 0x3C with NUM_REGS=8 -> RDATA=0, RRESP=10. Hold RREADY low 5 cycles -> RVALID and RDATA stay stable. Hold BREADY low -> no new AW is accepted.
- Reset mid-write: AW accepted, then ARESETN=0 for 1 cycle -> BVALID never asserts, all registers read 0 after release.

Source files
------------

// File: rtl/axi_lite_regbank.sv
// Parameterised AXI4-Lite slave register bank with per-register RW / RO / W1C behaviour,
// byte strobes, SLVERR on bad accesses and per-register write pulses.
module axi_lite_regbank #(
  parameter int                    C_S_AXI_DATA_WIDTH = 32,
  parameter int                    C_S_AXI_ADDR_WIDTH = 6,
  parameter int                    C_NUM_REGS         = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK          = '0,
  parameter logic [C_NUM_REGS-1:0] C_W1C_MASK         = '0
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_in,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_set,
  output logic [C_NUM_REGS-1:0]                    wr_pulse
);
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int SW  = DW / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = C_S_AXI_ADDR_WIDTH - LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e                        w_state_q, w_state_d;
  r_state_e                        r_state_q, r_state_d;
  logic                            aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
  logic [IW-1:0]                   waddr_q, waddr_d;
  logic [DW-1:0]                   wdata_q, wdata_d;
  logic [SW-1:0]                   wstrb_q, wstrb_d;
  logic                            awready_q, awready_d, wready_q, wready_d;
  logic                            bvalid_q, bvalid_d;
  logic [1:0]                      bresp_q, bresp_d;
  logic [C_NUM_REGS-1:0]           wr_pulse_q, wr_pulse_d;
  logic [C_NUM_REGS-1:0][DW-1:0]   regs_q, regs_d;
  logic                            arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]                      rresp_q, rresp_d;
  logic [DW-1:0]                   rdata_q, rdata_d;

  logic                            wr_en, wr_ro, wr_err;
  logic [C_NUM_REGS-1:0]           wr_hit;
  logic [DW-1:0]                   strb_mask, rd_val;
  logic [IW-1:0]                   rd_idx;
  logic                            rd_in_range;
  logic [C_NUM_REGS-1:0][DW-1:0]   reg_view;

  // RO registers expose hw_in directly; their stored flops are never written.
  always_comb begin
    for (int i = 0; i < C_NUM_REGS; i++)
      reg_view[i] = C_RO_MASK[i] ? hw_in[i*DW +: DW] : regs_q[i];
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign reg_out[g*DW +: DW] = reg_view[g];
  end

  always_comb begin
    wr_ro = 1'b0;
    for (int i = 0; i < C_NUM_REGS; i++)
      if (waddr_q == IW'(i)) wr_ro = C_RO_MASK[i];
    wr_err = (32'(waddr_q) >= C_NUM_REGS) || wr_ro;
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_lat_d  = aw_lat_q;
    w_lat_d   = w_lat_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_en     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awready_q && S_AXI_AWVALID) begin
          aw_lat_d = 1'b1;
          waddr_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
        end
        if (wready_q && S_AXI_WVALID) begin
          w_lat_d = 1'b1;
          wdata_d = S_AXI_WDATA;
          wstrb_d = S_AXI_WSTRB;
        end
        if (aw_lat_q && w_lat_q) begin
          wr_en     = 1'b1;
          aw_lat_d  = 1'b0;
          w_lat_d   = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    // Readies are registered from the next state so they are low throughout reset.
    awready_d = (w_state_d == W_IDLE) && !aw_lat_d;
    wready_d  = (w_state_d == W_IDLE) && !w_lat_d;
  end

  always_comb begin
    strb_mask = '0;
    wr_hit    = '0;
    for (int b = 0; b < SW; b++) strb_mask[b*8 +: 8] = {8{wstrb_q[b]}};
    for (int i = 0; i < C_NUM_REGS; i++) begin
      wr_hit[i] = wr_en && (waddr_q == IW'(i)) && !C_RO_MASK[i];
      regs_d[i] = regs_q[i];
      if (C_W1C_MASK[i] && !C_RO_MASK[i]) begin
        if (wr_hit[i]) regs_d[i] = regs_q[i] & ~(wdata_q & strb_mask);
        regs_d[i] = regs_d[i] | hw_set[i*DW +: DW];   // set beats a same-cycle clear
      end else if (wr_hit[i]) begin
        regs_d[i] = (regs_q[i] & ~strb_mask) | (wdata_q & strb_mask);
      end
    end
    wr_pulse_d = wr_hit;
  end

  always_comb begin
    rd_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
    rd_in_range = 32'(rd_idx) < C_NUM_REGS;
    rd_val      = '0;
    for (int i = 0; i < C_NUM_REGS; i++)
      if (rd_idx == IW'(i)) rd_val = reg_view[i];
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (arready_q && S_AXI_ARVALID) begin
          rdata_d   = rd_in_range ? rd_val : '0;
          rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_lat_q   <= 1'b0;
      w_lat_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      wr_pulse_q <= '0;
      regs_q     <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= '0;
      rdata_q    <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_lat_q   <= aw_lat_d;
      w_lat_q    <= w_lat_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign wr_pulse      = wr_pulse_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0],
                       S_AXI_ARADDR[LSB-1:0], hw_in, hw_set};
endmodule

// File: tb/tb_axi_lite_regbank.sv
// Scoreboard bench for axi_lite_regbank: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them; directed checks cover timing and stability.
module tb_axi_lite_regbank;
  localparam int DW = 32, AW = 6, NR = 8;
  localparam logic [NR-1:0] RO_M = 8'h08, W1C_M = 8'h04;

  logic clk = 1'b0, aresetn = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1;
  logic arvalid = 0, arready, rvalid, rready = 1;
  logic [DW-1:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [NR*DW-1:0] reg_out, hw_in, hw_set;
  logic [NR-1:0] wr_pulse;

  always #5 clk = ~clk;

  axi_lite_regbank #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .C_NUM_REGS(NR),
                     .C_RO_MASK(RO_M), .C_W1C_MASK(W1C_M)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .hw_in(hw_in), .hw_set(hw_set), .wr_pulse(wr_pulse));

  typedef struct packed { logic [31:0] data; logic [1:0] resp; } rexp_t;
  logic [1:0] bq[$];
  rexp_t      rq[$];
  int checks = 0, failures = 0;
  int pulse_cnt[NR], exp_pulse[NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: handshake timed out at %0t", name, $time);
  endtask

  // Monitor: compares every completed B / R beat against the scoreboard.
  always @(negedge clk) begin
    if (aresetn) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) timeout("b_unexpected");
        else chk("bresp", 64'(bresp), 64'(bq.pop_front()));
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) timeout("r_unexpected");
        else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rdata", 64'(rdata), 64'(e.data));
          chk("rresp", 64'(rresp), 64'(e.resp));
        end
      end
      for (int i = 0; i < NR; i++) pulse_cnt[i] += int'(wr_pulse[i]);
    end
  end

  task automatic do_hs(input logic [AW-1:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int aw_delay);
    bit aw_pend = 1, w_pend = 1, aw_hs, w_hs;
    int n = 0;
    awaddr = addr; wdata = data; wstrb = strb; wvalid = 1;
    while ((aw_pend || w_pend) && n < 20) begin
      if (n >= aw_delay && aw_pend) awvalid = 1;
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 0; aw_pend = 0; end
      if (w_hs)  begin wvalid = 0;  w_pend = 0;  end
      n++;
    end
    if (aw_pend || w_pend) begin
      timeout("wr_handshake");
      awvalid = 0; wvalid = 0;
    end
  endtask

  // BVALID must be low until the update edge and high right after it.
  task automatic b_phase();
    @(negedge clk); chk("b_early", 64'(bvalid), 64'(0));
    @(negedge clk); chk("b_latency", 64'(bvalid), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input int aw_delay = 0);
    bq.push_back(resp);
    if (resp == 2'b00) exp_pulse[int'(addr) >> 2]++;
    do_hs(addr, data, strb, aw_delay);
    b_phase();
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int hold = 0);
    bit done = 0;
    int n = 0;
    rq.push_back(rexp_t'{data: exp_data, resp: exp_resp});
    araddr = addr; arvalid = 1; rready = (hold == 0);
    while (!done && n < 20) begin
      @(negedge clk); done = arready;
      @(posedge clk); #1;
      n++;
    end
    arvalid = 0;
    if (!done) begin
      timeout("rd_handshake");
      rready = 1;
      return;
    end
    @(negedge clk); chk("r_latency", 64'(rvalid), 64'(1));
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("r_hold_valid", 64'(rvalid), 64'(1));
        chk("r_hold_data", 64'(rdata), 64'(exp_data));
      end
      @(posedge clk); #1;
      rready = 1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    for (int i = 0; i < NR; i++) begin pulse_cnt[i] = 0; exp_pulse[i] = 0; end
    hw_in = {NR{32'hFFFF_FFFF}};
    hw_in[3*DW +: DW] = 32'h0000_DEAD;
    hw_set = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(awready), 64'(0));
    chk("rst_wready", 64'(wready), 64'(0));
    chk("rst_arready", 64'(arready), 64'(0));
    chk("rst_bvalid", 64'(bvalid), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_resp_data", 64'({bresp, rresp, rdata}), 64'(0));
    chk("rst_wr_pulse", 64'(wr_pulse), 64'(0));
    chk("rst_reg0", 64'(reg_out[0 +: DW]), 64'(0));
    @(posedge clk); #1 aresetn = 1;
    @(posedge clk); #1;

    // Sequential RW (reg2 is W1C, reg3 is RO)
    for (int i = 0; i < NR; i++)
      axi_write(AW'(i*4), 32'(i+1), 4'hF, (i == 3) ? 2'b10 : 2'b00);
    axi_read(6'h00, 32'h1, 2'b00);
    axi_read(6'h04, 32'h2, 2'b00);
    axi_read(6'h08, 32'h0, 2'b00);
    axi_read(6'h0C, 32'hDEAD, 2'b00);
    axi_read(6'h10, 32'h5, 2'b00);
    axi_read(6'h14, 32'h6, 2'b00);
    axi_read(6'h18, 32'h7, 2'b00);
    axi_read(6'h1C, 32'h8, 2'b00);

    // Byte strobes
    axi_write(6'h00, 32'hAABBCCDD, 4'hF, 2'b00);
    axi_write(6'h00, 32'h11223344, 4'b0101, 2'b00);
    axi_read(6'h00, 32'hAA22CC44, 2'b00);

    // W ahead of AW, then both together
    axi_write(6'h04, 32'h12345678, 4'hF, 2'b00, 3);
    axi_write(6'h10, 32'h0BADF00D, 4'hF, 2'b00, 0);
    axi_read(6'h04, 32'h12345678, 2'b00);
    axi_read(6'h10, 32'h0BADF00D, 2'b00);

    // W1C
    hw_set[2*DW +: DW] = 32'hF0;
    @(posedge clk); #1 hw_set = '0;
    axi_write(6'h08, 32'h30, 4'hF, 2'b00);
    axi_read(6'h08, 32'hC0, 2'b00);
    bq.push_back(2'b00); exp_pulse[2]++;
    do_hs(6'h08, 32'h40, 4'hF, 0);
    hw_set[2*DW +: DW] = 32'h40;            // present only on the update edge
    @(negedge clk); chk("b_early", 64'(bvalid), 64'(0));
    @(posedge clk); #1 hw_set = '0;
    @(negedge clk); chk("b_latency", 64'(bvalid), 64'(1));
    @(posedge clk); #1;
    axi_read(6'h08, 32'hC0, 2'b00);
    axi_write(6'h08, 32'h80, 4'hF, 2'b00);
    axi_read(6'h08, 32'h40, 2'b00);
    chk("w1c_reg_out", 64'(reg_out[2*DW +: DW]), 64'h40);

    // RO
    axi_read(6'h0C, 32'hDEAD, 2'b00);
    axi_write(6'h0C, 32'h1234, 4'hF, 2'b10);
    axi_read(6'h0C, 32'hDEAD, 2'b00);
    chk("ro_reg_out", 64'(reg_out[3*DW +: DW]), 64'hDEAD);

    // Out-of-range and R backpressure
    axi_read(6'h3C, 32'h0, 2'b10, 5);
    axi_write(6'h20, 32'h77, 4'hF, 2'b10);
    axi_read(6'h14, 32'h6, 2'b00, 3);

    // B backpressure blocks the next AW
    bready = 0;
    bq.push_back(2'b00); exp_pulse[1]++;
    do_hs(6'h04, 32'h55, 4'hF, 0);
    @(negedge clk); @(negedge clk);
    chk("b_held", 64'(bvalid), 64'(1));
    @(posedge clk); #1;
    awaddr = 6'h18; awvalid = 1;
    repeat (4) begin
      @(negedge clk);
      chk("aw_blocked", 64'(awready), 64'(0));
      chk("b_hold", 64'(bvalid), 64'(1));
      @(posedge clk); #1;
    end
    bready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    axi_write(6'h18, 32'h66, 4'hF, 2'b00);
    axi_read(6'h04, 32'h55, 2'b00);
    axi_read(6'h18, 32'h66, 2'b00);

    // Reset during a write
    awaddr = 6'h00; awvalid = 1;
    @(negedge clk); chk("rst_mid_aw_ready", 64'(awready), 64'(1));
    @(posedge clk); #1;
    awvalid = 0; wdata = 32'hCAFE; wstrb = 4'hF; wvalid = 1; aresetn = 0;
    @(posedge clk); #1 aresetn = 1; wvalid = 0;
    bad = 0;
    repeat (6) begin @(negedge clk); if (bvalid) bad++; end
    chk("rst_mid_no_bvalid", 64'(bad), 64'(0));
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++)
      axi_read(AW'(i*4), (i == 3) ? 32'hDEAD : 32'h0, 2'b00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bq_drained", 64'(bq.size()), 64'(0));
    chk("rq_drained", 64'(rq.size()), 64'(0));
    for (int i = 0; i < NR; i++)
      chk($sformatf("wr_pulse_count[%0d]", i), 64'(pulse_cnt[i]), 64'(exp_pulse[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
